// File: rtl/esaxi_read_sequencer.sv
// Backend read sequencer for the Emesh AXI slave read bridge: one backend read per beat, lane extraction, R-channel pacing.
// Optional response timeout enabled by defining ESAXI_RD_TIMEOUT_EN.
module esaxi_read_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TO_W           = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_ractive,
   input  logic [31:0] tx_araddr,
   input  logic [2:0]  tx_arsize,
   input  logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   input  logic        s_axi_rlast,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   output logic [1:0]  mem_req_size,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        read_valid,
   output logic [7:0]  read_data_7_0,
   output logic [15:0] read_data_15_0,
   output logic [31:0] read_data_31_0,
   output logic [1:0]  read_resp,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_RSP,
      S_PRESENT,
      S_HOLD,
      S_SETTLE
   } state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [7:0]  lane8_c;
   logic [15:0] lane16_c;
   logic        to_hit_c;
   logic        unused_bits;

   // Counter must be able to represent TIMEOUT_CYCLES.
   if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_to_w_check
      $error("TO_W is too narrow for TIMEOUT_CYCLES");
   end

   assign unused_bits = tx_arsize[2];

   // Byte and halfword lanes selected by the beat's low address bits.
   assign lane8_c  = 8'(mem_rsp_data >> {addr_q[1:0], 3'b000});
   assign lane16_c = addr_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

`ifdef ESAXI_RD_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   // Counts WAIT_RSP cycles; held at zero everywhere else so entry starts from 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state != S_WAIT_RSP) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign to_hit_c = (state == S_WAIT_RSP) && !mem_rsp_valid &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign to_hit_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         addr_q         <= '0;
         mem_req_valid  <= 1'b0;
         mem_req_addr   <= '0;
         mem_req_size   <= '0;
         read_valid     <= 1'b0;
         read_data_7_0  <= '0;
         read_data_15_0 <= '0;
         read_data_31_0 <= '0;
         read_resp      <= 2'b00;
         busy           <= 1'b0;
      end else begin
         read_valid <= 1'b0;
         case (state)
            S_IDLE, S_SETTLE: begin
               if (tx_ractive) begin
                  state         <= S_REQ;
                  addr_q        <= tx_araddr;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {tx_araddr[31:2], 2'b00};
                  mem_req_size  <= tx_arsize[1:0];
                  busy          <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  state         <= S_WAIT_RSP;
                  mem_req_valid <= 1'b0;
               end else if (!tx_ractive) begin
                  state         <= S_IDLE;
                  mem_req_valid <= 1'b0;
                  busy          <= 1'b0;
               end
            end
            S_WAIT_RSP: begin
               // A response beats a simultaneous timeout; a burst abort discards either.
               if (mem_rsp_valid || to_hit_c) begin
                  if (!tx_ractive) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state      <= S_PRESENT;
                     read_valid <= 1'b1;
                     if (mem_rsp_valid) begin
                        read_data_7_0  <= lane8_c;
                        read_data_15_0 <= lane16_c;
                        read_data_31_0 <= mem_rsp_data;
                        read_resp      <= mem_rsp_err ? 2'b10 : 2'b00;
                     end else begin
                        read_data_7_0  <= '0;
                        read_data_15_0 <= '0;
                        read_data_31_0 <= '0;
                        read_resp      <= 2'b10;
                     end
                  end
               end
            end
            S_PRESENT: begin
               state <= S_HOLD;
            end
            S_HOLD: begin
               if (!tx_ractive) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (s_axi_rvalid && s_axi_rready) begin
                  if (s_axi_rlast) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_SETTLE;
                  end
               end
            end
            default: begin
               state         <= S_IDLE;
               mem_req_valid <= 1'b0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_esaxi_read_sequencer.sv
// Scoreboard bench for esaxi_read_sequencer: directed beats, bursts, backpressure, errors, aborts, reset and timeout.
module tb_esaxi_read_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_ractive;
   logic [31:0] tx_araddr;
   logic [2:0]  tx_arsize;
   logic        s_axi_rvalid, s_axi_rready, s_axi_rlast;
   logic        mem_req_valid, mem_req_ready;
   logic [31:0] mem_req_addr;
   logic [1:0]  mem_req_size;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        read_valid;
   logic [7:0]  read_data_7_0;
   logic [15:0] read_data_15_0;
   logic [31:0] read_data_31_0;
   logic [1:0]  read_resp;
   logic        busy;

   typedef struct {
      logic [7:0]  d7;
      logic [15:0] d15;
      logic [31:0] d31;
      logic [1:0]  resp;
   } beat_t;

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
   } req_t;

   beat_t beat_q[$];
   req_t  req_q[$];
   int    tests = 0;
   int    fails = 0;
   int    rv_count = 0;
   logic  req_prev = 1'b0;

   esaxi_read_sequencer #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
      .clk(clk), .rst(rst),
      .tx_ractive(tx_ractive), .tx_araddr(tx_araddr), .tx_arsize(tx_arsize),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rlast(s_axi_rlast),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_size(mem_req_size),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
      .read_valid(read_valid), .read_data_7_0(read_data_7_0), .read_data_15_0(read_data_15_0),
      .read_data_31_0(read_data_31_0), .read_resp(read_resp), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops expected beats on read_valid and expected requests on each new request.
   always @(negedge clk) begin
      if (!rst) begin
         if (read_valid) begin
            rv_count++;
            if (beat_q.size() == 0) begin
               check("rv_unexpected", 32'(read_valid), 32'd0);
            end else begin
               beat_t e;
               e = beat_q.pop_front();
               check("lane7_0", 32'(read_data_7_0), 32'(e.d7));
               check("lane15_0", 32'(read_data_15_0), 32'(e.d15));
               check("lane31_0", read_data_31_0, e.d31);
               check("read_resp", 32'(read_resp), 32'(e.resp));
            end
         end
         if (mem_req_valid && !req_prev) begin
            if (req_q.size() == 0) begin
               check("req_unexpected", 32'(mem_req_valid), 32'd0);
            end else begin
               req_t r;
               r = req_q.pop_front();
               check("req_addr", mem_req_addr, r.addr);
               check("req_size", 32'(mem_req_size), 32'(r.size));
            end
         end
      end
      req_prev = rst ? 1'b0 : mem_req_valid;
   end

   // Wait for the request, optionally stall it, then accept it.
   task automatic issue(input logic [31:0] req_addr, input logic [1:0] sz, input int stall);
      int n;
      req_q.push_back('{req_addr, sz});
      n = 0;
      while (!mem_req_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", 32'(mem_req_valid), 32'd1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("req_hold_valid", 32'(mem_req_valid), 32'd1);
         check("req_hold_addr", mem_req_addr, req_addr);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("req_dropped", 32'(mem_req_valid), 32'd0);
   endtask

   // Respond, then let the bridge accept the beat after bp stalled cycles.
   task automatic finish_beat(input logic [31:0] data, input logic err, input int rdly, input int bp,
                              input logic last, input logic [31:0] next_addr,
                              input logic [7:0] d7, input logic [15:0] d15);
      repeat (rdly) @(negedge clk);
      beat_q.push_back('{d7, d15, data, err ? 2'b10 : 2'b00});
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data;
      mem_rsp_err   = err;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'h0BAD_0BAD;
      mem_rsp_err   = 1'b0;
      check("rv_pulse", 32'(read_valid), 32'd1);
      @(negedge clk);
      check("rv_single", 32'(read_valid), 32'd0);
      s_axi_rvalid = 1'b1;
      s_axi_rready = 1'b0;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check("bp_no_req", 32'(mem_req_valid), 32'd0);
         check("bp_stable", read_data_31_0, data);
      end
      s_axi_rready = 1'b1;
      s_axi_rlast  = last;
      @(negedge clk);
      s_axi_rvalid = 1'b0;
      s_axi_rready = 1'b0;
      s_axi_rlast  = 1'b0;
      if (last) tx_ractive = 1'b0;
      else      tx_araddr  = next_addr;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rv0;
      rst = 1'b1; tx_ractive = 1'b0; tx_araddr = '0; tx_arsize = '0;
      s_axi_rvalid = 1'b0; s_axi_rready = 1'b0; s_axi_rlast = 1'b0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_req_addr", mem_req_addr, 32'd0);
      check("rst_req_size", 32'(mem_req_size), 32'd0);
      check("rst_read_valid", 32'(read_valid), 32'd0);
      check("rst_d7", 32'(read_data_7_0), 32'd0);
      check("rst_d15", 32'(read_data_15_0), 32'd0);
      check("rst_d31", read_data_31_0, 32'd0);
      check("rst_resp", 32'(read_resp), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // Single beat, byte lane 2
      tx_araddr = 32'h1000_0006; tx_arsize = 3'd0; tx_ractive = 1'b1;
      issue(32'h1000_0004, 2'd0, 0);
      finish_beat(32'hAABB_CCDD, 1'b0, 2, 0, 1'b1, 32'h0, 8'hBB, 16'hAABB);
      @(negedge clk);
      check("single_idle", 32'(busy), 32'd0);

      // 4-beat INCR burst: stall on beat 2, R backpressure on beat 3
      rv0 = rv_count;
      tx_araddr = 32'h0; tx_arsize = 3'd2; tx_ractive = 1'b1;
      issue(32'h0, 2'd2, 0);
      finish_beat(32'h1122_3344, 1'b0, 1, 0, 1'b0, 32'h4, 8'h44, 16'h3344);
      issue(32'h4, 2'd2, 3);
      finish_beat(32'h5566_7788, 1'b0, 0, 0, 1'b0, 32'h8, 8'h88, 16'h7788);
      issue(32'h8, 2'd2, 0);
      finish_beat(32'h99AA_BBCC, 1'b0, 3, 10, 1'b0, 32'hC, 8'hCC, 16'hBBCC);
      issue(32'hC, 2'd2, 0);
      finish_beat(32'hDDEE_FF00, 1'b0, 0, 0, 1'b1, 32'h0, 8'h00, 16'hFF00);
      @(negedge clk);
      check("burst_pulses", 32'(rv_count - rv0), 32'd4);
      check("burst_idle", 32'(busy), 32'd0);

      // Byte lane 3 / upper halfword, halfword size
      tx_araddr = 32'h0000_0103; tx_arsize = 3'd1; tx_ractive = 1'b1;
      issue(32'h0000_0100, 2'd1, 0);
      finish_beat(32'hCAFE_F00D, 1'b0, 1, 0, 1'b1, 32'h0, 8'hCA, 16'hCAFE);
      @(negedge clk);

      // Byte lane 1 / lower halfword
      tx_araddr = 32'h0000_2001; tx_arsize = 3'd0; tx_ractive = 1'b1;
      issue(32'h0000_2000, 2'd0, 0);
      finish_beat(32'h1234_5678, 1'b0, 0, 2, 1'b1, 32'h0, 8'h56, 16'h5678);
      @(negedge clk);

      // Error response still forwards data
      tx_araddr = 32'h0000_0040; tx_arsize = 3'd2; tx_ractive = 1'b1;
      issue(32'h0000_0040, 2'd2, 0);
      finish_beat(32'hDEAD_BEEF, 1'b1, 1, 0, 1'b1, 32'h0, 8'hEF, 16'hBEEF);
      @(negedge clk);

      // Burst abort in WAIT_RSP: response discarded
      tx_araddr = 32'h0000_0500; tx_arsize = 3'd2; tx_ractive = 1'b1;
      issue(32'h0000_0500, 2'd2, 0);
      tx_ractive = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_kept_busy", 32'(busy), 32'd1);
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("abort_no_rv", 32'(read_valid), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_data_kept", read_data_31_0, 32'hDEAD_BEEF);

      // Reset in WAIT_RSP
      tx_araddr = 32'h0000_0300; tx_arsize = 3'd2; tx_ractive = 1'b1;
      issue(32'h0000_0300, 2'd2, 0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_addr", mem_req_addr, 32'd0);
      check("mid_rst_size", 32'(mem_req_size), 32'd0);
      check("mid_rst_d31", read_data_31_0, 32'd0);
      check("mid_rst_d7", 32'(read_data_7_0), 32'd0);
      check("mid_rst_resp", 32'(read_resp), 32'd0);
      rst = 1'b0; tx_ractive = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_5555;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check("post_rst_no_rv", 32'(read_valid), 32'd0);
      check("post_rst_idle", 32'(busy), 32'd0);

`ifdef ESAXI_RD_TIMEOUT_EN
      // Timeout after 8 WAIT_RSP cycles; late response ignored
      begin
         int n;
         tx_araddr = 32'h0000_0080; tx_arsize = 3'd2; tx_ractive = 1'b1;
         issue(32'h0000_0080, 2'd2, 0);
         beat_q.push_back('{8'h00, 16'h0000, 32'h0, 2'b10});
         n = 0;
         while (!read_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("timeout_cycles", 32'(n), 32'd8);
         @(negedge clk);
         mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         check("late_rsp_no_rv", 32'(read_valid), 32'd0);
         check("late_rsp_data", read_data_31_0, 32'd0);
         s_axi_rvalid = 1'b1; s_axi_rready = 1'b1; s_axi_rlast = 1'b1;
         @(negedge clk);
         s_axi_rvalid = 1'b0; s_axi_rready = 1'b0; s_axi_rlast = 1'b0; tx_ractive = 1'b0;
         @(negedge clk);
         check("timeout_idle", 32'(busy), 32'd0);
      end
`endif

      repeat (3) @(negedge clk);
      check("beats_drained", 32'(beat_q.size()), 32'd0);
      check("reqs_drained", 32'(req_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
